// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched uops until both operands are
// available, snoops both result buses, and issues one ready uop per cycle.
module alu_rs #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_value1,
  input  logic [TAG_W-1:0]  in_tag1,
  input  logic [DATA_W-1:0] in_value2,
  input  logic [TAG_W-1:0]  in_tag2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_rob_tag,
  input  logic [TAG_W-1:0]  in_alu_cdb_tag,
  input  logic [DATA_W-1:0] in_alu_cdb_value,
  input  logic [TAG_W-1:0]  in_lsb_cdb_tag,
  input  logic [DATA_W-1:0] in_lsb_cdb_value,
  input  logic              in_rollback,
  output logic              out_full,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_value1,
  output logic [DATA_W-1:0] out_value2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [TAG_W-1:0]  out_rob_tag
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int unsigned OPND_W = TAG_W + DATA_W;

  logic [RS_SIZE-1:0] busy;
  logic [OP_W-1:0]    ent_op   [RS_SIZE];
  logic [DATA_W-1:0]  ent_val1 [RS_SIZE];
  logic [TAG_W-1:0]   ent_tag1 [RS_SIZE];
  logic [DATA_W-1:0]  ent_val2 [RS_SIZE];
  logic [TAG_W-1:0]   ent_tag2 [RS_SIZE];
  logic [DATA_W-1:0]  ent_imm  [RS_SIZE];
  logic [DATA_W-1:0]  ent_pc   [RS_SIZE];
  logic [TAG_W-1:0]   ent_rob  [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   issue_idx;
  logic               issue_found;
  logic [OPND_W-1:0]  disp_opnd1;
  logic [OPND_W-1:0]  disp_opnd2;

  // Resolve an operand against both result buses; ALU bus wins on a double match.
  function automatic logic [OPND_W-1:0] snoop(input logic [TAG_W-1:0]  tag,
                                              input logic [DATA_W-1:0] val);
    logic [OPND_W-1:0] res;
    res = {tag, val};
    if (tag != '0 && tag == in_alu_cdb_tag)
      res = {TAG_W'(0), in_alu_cdb_value};
    else if (tag != '0 && tag == in_lsb_cdb_tag)
      res = {TAG_W'(0), in_lsb_cdb_value};
    return res;
  endfunction

  assign out_full = &busy;

  // Lowest-index free slot and lowest-index ready slot.
  always_comb begin
    ready       = '0;
    free_idx    = '0;
    issue_idx   = '0;
    issue_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy[i] && (ent_tag1[i] == '0) && (ent_tag2[i] == '0);
      if (!busy[i])
        free_idx = IDX_W'(i);
      if (ready[i]) begin
        issue_idx   = IDX_W'(i);
        issue_found = 1'b1;
      end
    end
  end

  always_comb begin
    disp_opnd1 = snoop(in_tag1, in_value1);
    disp_opnd2 = snoop(in_tag2, in_value2);
  end

  // Entry payloads are only read while busy, so only control state is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      out_op      <= '0;
      out_value1  <= '0;
      out_value2  <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rob_tag <= '0;
    end else if (in_rollback) begin
      busy        <= '0;
      out_op      <= '0;
      out_value1  <= '0;
      out_value2  <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rob_tag <= '0;
    end else if (!rdy) begin
      out_op      <= '0;
      out_value1  <= '0;
      out_value2  <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rob_tag <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          {ent_tag1[i], ent_val1[i]} <= snoop(ent_tag1[i], ent_val1[i]);
          {ent_tag2[i], ent_val2[i]} <= snoop(ent_tag2[i], ent_val2[i]);
        end
      end

      if (issue_found) begin
        busy[issue_idx] <= 1'b0;
        out_op          <= ent_op[issue_idx];
        out_value1      <= ent_val1[issue_idx];
        out_value2      <= ent_val2[issue_idx];
        out_imm         <= ent_imm[issue_idx];
        out_pc          <= ent_pc[issue_idx];
        out_rob_tag     <= ent_rob[issue_idx];
      end else begin
        out_op      <= '0;
        out_value1  <= '0;
        out_value2  <= '0;
        out_imm     <= '0;
        out_pc      <= '0;
        out_rob_tag <= '0;
      end

      // The free slot is never the issuing slot, so these writes never collide.
      if (in_valid && !out_full) begin
        busy[free_idx]                         <= 1'b1;
        ent_op[free_idx]                       <= in_op;
        {ent_tag1[free_idx], ent_val1[free_idx]} <= disp_opnd1;
        {ent_tag2[free_idx], ent_val2[free_idx]} <= disp_opnd2;
        ent_imm[free_idx]                      <= in_imm;
        ent_pc[free_idx]                       <= in_pc;
        ent_rob[free_idx]                      <= in_rob_tag;
      end
    end
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the ALU. Holds dispatched integer, branch and jump µops until both source operands are available, then issues one ready µop per cycle to the combinational ALU.
- Snoops the two result buses (ALU and LSB) to wake waiting operands.
- Sits between dispatch/decode and the ALU. Its outputs drive the ALU inputs directly.

Parameters:
- RS_SIZE, 8: number of entries.
- TAG_W, 4: ROB tag width. Tag 0 is reserved and means "no tag / operand ready".
- OP_W, 6: internal opcode width. Opcode 0 is NOP.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready. Low means the block stalls.
- in_valid  in  1  dispatch request this cycle
- in_op  in  OP_W  internal opcode
- in_value1  in  DATA_W  operand 1 value; meaningful when in_tag1 == 0
- in_tag1  in  TAG_W  producer ROB tag of operand 1; 0 means ready
- in_value2  in  DATA_W  operand 2 value
- in_tag2  in  TAG_W  producer ROB tag of operand 2
- in_imm  in  DATA_W  immediate
- in_pc  in  DATA_W  instruction PC
- in_rob_tag  in  TAG_W  destination ROB tag, nonzero
- in_alu_cdb_tag  in  TAG_W  ALU result tag; 0 means no broadcast
- in_alu_cdb_value  in  DATA_W  ALU result value
- in_lsb_cdb_tag  in  TAG_W  LSB result tag; 0 means no broadcast
- in_lsb_cdb_value  in  DATA_W  LSB result value
- in_rollback  in  1  misprediction flush
- out_full  out  1  all entries busy
- out_op  out  OP_W  to ALU: opcode, NOP when idle
- out_value1  out  DATA_W  to ALU
- out_value2  out  DATA_W  to ALU
- out_imm  out  DATA_W  to ALU
- out_pc  out  DATA_W  to ALU
- out_rob_tag  out  TAG_W  to ALU

Behaviour:
- **Reset** (asynchronous, active-high): all entries become not busy. All out_* registers go to 0 (out_op = NOP). out_full = 0.
- **Entry state**: busy, op, value1, tag1, value2, tag2, imm, pc, rob_tag.
  - An entry is ready when busy, tag1 == 0 and tag2 == 0.
- **out_full**: combinational from registered state; 1 when every entry is busy.
  - An entry freed by issue in the current cycle does not clear out_full until the next cycle.
- **Dispatch**: on posedge with rdy = 1, in_valid = 1, !out_full and !in_rollback, the µop is written into the lowest-index free entry.
  - in_valid while out_full is a protocol violation; the request is ignored and state is unchanged.
- **Dispatch-time forwarding**: if in_tagN != 0 and in_tagN equals a nonzero CDB tag in the same cycle, store that CDB value with tagN = 0. The ALU bus takes priority if both buses match.
- **Wake-up**: every busy entry with tagN != 0 that matches a nonzero CDB tag captures the value and sets tagN = 0 at the posedge.
  - The entry becomes eligible for issue on the following cycle, never in the same cycle.
- **Issue**: each cycle with rdy = 1, select the lowest-index ready entry from registered state.
  - Register its fields onto out_* and clear its busy bit at the posedge.
  - If no entry is ready, out_op = NOP and out_rob_tag = 0; the other outputs are don't-care (drive 0).
  - Latency: a µop dispatched with both tags 0 appears on out_* one cycle after the dispatch edge (edge N writes the entry, edge N+1 issues it). Minimum dispatch-to-ALU-result latency is 2 edges.
  - One issue per cycle. Dispatch and issue may occur in the same cycle on different entries.
- **rdy = 0**: no entry state changes; out_op is driven NOP and out_rob_tag 0 at the next edge; CDB inputs are ignored. The upstream side guarantees broadcasts are not lost, because the CDBs are also stalled when rdy = 0.
- **Rollback** (priority over dispatch, wake-up and issue): at the posedge all entries become not busy and out_op becomes NOP. The concurrent dispatch is dropped. rdy has no gating effect on rollback.
- **Tag 0 on a CDB** never matches anything.
- **Reset mid-operation**: immediate clear, regardless of clk and rdy.

Test Plan:
- **Reset then idle**: assert rst for 2 cycles, release, no dispatch → out_op = 0 and out_full = 0 every cycle.
- **Ready dispatch**: ADD with value1 = 5, value2 = 7, tags 0, rob_tag = 3 at edge 0 → at edge 1 out_op = ADD, out_value1 = 5, out_value2 = 7, out_rob_tag = 3; at edge 2 out_op = NOP.
- **Wake-up**: dispatch SUB with tag1 = 4, value2 = 1, rob_tag = 5. At cycle 3 drive lsb_cdb_tag = 4, value = 10 → no issue at edge 3; issue at edge 4 with out_value1 = 10, out_value2 = 1, out_rob_tag = 5.
- **Dispatch forwarding**: dispatch with tag2 = 6 while alu_cdb_tag = 6 and value = 0x1234 in the same cycle → issues next edge with out_value2 = 0x1234.
- **Full and ordering**: dispatch 8 µops each waiting on tag 9, then out_full = 1 and a 9th in_valid is ignored. Broadcast tag 9 → the entries issue in index order, one per cycle, over 8 consecutive cycles. out_full drops the cycle after the first issue.
- **Rollback**: 3 waiting entries, pulse in_rollback together with a ready dispatch → no µop ever issues, out_full = 0, and a later broadcast of the waited tag produces no issue.
